// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring unsigned divider
//
// Purpose: divides dividend by divisor one quotient bit per clock using
// restoring division. IDLE -> RUN (WIDTH steps) -> DONE (one cycle) -> IDLE.
// Optional macro SEQ_DIVIDER_ZERO_FAST_EN: a zero divisor skips RUN and goes
// straight to DONE with the divide-by-zero result.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        division request, sampled only in IDLE
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while in RUN
//   done         high for the single DONE cycle
//   quotient     registered quotient of the last completed division
//   remainder    registered remainder of the last completed division
//   div_by_zero  registered; last completed division had divisor 0
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;

   logic [WIDTH-1:0] dvd_sh;   // captured dividend, MSB is the next bit to bring in
   logic [WIDTH-1:0] dvs;      // captured divisor
   logic [WIDTH-1:0] rem_p;    // partial remainder
   logic [WIDTH-1:0] quo_sh;   // quotient bits collected so far
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             qbit;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             last;
   logic             fast_zero;

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
   assign fast_zero = (divisor == '0);
`else
   assign fast_zero = 1'b0;
`endif

   assign last = (cnt == CW'(WIDTH - 1));

   // The partial remainder is always below the divisor, so the shifted value
   // is below twice the divisor and the top bit of the (WIDTH+1)-bit
   // difference is a reliable sign bit. With a zero divisor the shifted-in
   // value never reaches bit WIDTH, so every quotient bit comes out as 1
   // and the remainder ends up equal to the dividend.
   always_comb begin
      shifted  = {rem_p, dvd_sh[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      qbit     = ~diff[WIDTH];
      step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_quo = {quo_sh[WIDTH-2:0], qbit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = fast_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_sh      <= '0;
         dvs         <= '0;
         rem_p       <= '0;
         quo_sh      <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_sh <= dividend;
                  dvs    <= divisor;
                  rem_p  <= '0;
                  quo_sh <= '0;
                  cnt    <= '0;
                  if (fast_zero) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
               rem_p  <= step_rem;
               quo_sh <= step_quo;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  cnt         <= '0;
                  quotient    <= step_quo;
                  remainder   <= step_rem;
                  div_by_zero <= (dvs == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int passed = 0;
   int total  = 0;
   int overlap = 0;
   int edges;
   int bcnt;

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
   localparam int ZLAT  = 1;
   localparam int ZBUSY = 0;
`else
   localparam int ZLAT  = 33;
   localparam int ZBUSY = 32;
`endif

   seq_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Present operands with start high and pass the acceptance edge E0.
   task automatic accept(input logic [31:0] a, input logic [31:0] b, input bit hold);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Count edges (E0 counted as e0 already passed) until done is seen.
   task automatic wait_done(input int e0, output int e, output int bc);
      e  = e0;
      bc = 0;
      if (busy) bc++;
      while (!done && e < 200) begin
         @(posedge clk);
         #1;
         e++;
         if (busy) bc++;
         if (busy && done) overlap++;
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quo", quotient, 32'd0);
      check("rst_rem", remainder, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 100 / 7
      accept(32'd100, 32'd7, 1'b0);
      wait_done(1, edges, bcnt);
      check("d100_lat", 32'(edges), 32'd33);
      check("d100_busy", 32'(bcnt), 32'd32);
      check("d100_quo", quotient, 32'd14);
      check("d100_rem", remainder, 32'd2);
      check("d100_dbz", 32'(div_by_zero), 32'd0);
      @(posedge clk);
      #1;
      check("d100_pulse", 32'(done), 32'd0);
      check("d100_idle", 32'(busy), 32'd0);
      check("d100_hold", quotient, 32'd14);

      // 0xFFFFFFFF / 1
      accept(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_done(1, edges, bcnt);
      check("dmax_lat", 32'(edges), 32'd33);
      check("dmax_quo", quotient, 32'hFFFF_FFFF);
      check("dmax_rem", remainder, 32'd0);
      @(posedge clk);
      #1;

      // 5 / 9
      accept(32'd5, 32'd9, 1'b0);
      wait_done(1, edges, bcnt);
      check("d5_quo", quotient, 32'd0);
      check("d5_rem", remainder, 32'd5);
      @(posedge clk);
      #1;

      // 50 / 3 with start held, then a 9 / 2 re-pulse during RUN
      accept(32'd50, 32'd3, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      dividend = 32'd9;
      divisor  = 32'd2;
      start    = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(6, edges, bcnt);
      check("d50_lat", 32'(edges), 32'd33);
      check("d50_quo", quotient, 32'd16);
      check("d50_rem", remainder, 32'd2);
      @(posedge clk);
      #1;

      // 0x12345678 / 0
      accept(32'h1234_5678, 32'd0, 1'b0);
      wait_done(1, edges, bcnt);
      check("dz_lat", 32'(edges), 32'(ZLAT));
      check("dz_busy", 32'(bcnt), 32'(ZBUSY));
      check("dz_quo", quotient, 32'hFFFF_FFFF);
      check("dz_rem", remainder, 32'h1234_5678);
      check("dz_dbz", 32'(div_by_zero), 32'd1);
      @(posedge clk);
      #1;
      check("dz_pulse", 32'(done), 32'd0);

      // reset 10 cycles into RUN
      accept(32'd100, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      check("ab_running", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_done", 32'(done), 32'd0);
      check("ab_quo", quotient, 32'd0);
      check("ab_rem", remainder, 32'd0);
      check("ab_dbz", 32'(div_by_zero), 32'd0);
      accept(32'd81, 32'd9, 1'b0);
      check("ab_restart", 32'(busy), 32'd1);
      wait_done(1, edges, bcnt);
      check("d81_lat", 32'(edges), 32'd33);
      check("d81_quo", quotient, 32'd9);
      check("d81_rem", remainder, 32'd0);
      @(posedge clk);
      #1;

      // back-to-back with start held high
      accept(32'd1000, 32'd10, 1'b1);
      for (int k = 0; k < 3; k++) begin
         wait_done(1, edges, bcnt);
         check("b2b_lat", 32'(edges), 32'd33);
         check("b2b_quo", quotient, 32'd100);
         check("b2b_rem", remainder, 32'd0);
         @(posedge clk);
         #1;
         check("b2b_idle", 32'(busy | done), 32'd0);
         @(posedge clk);
         #1;
         check("b2b_run", 32'(busy), 32'd1);
      end
      start = 1'b0;
      wait_done(1, edges, bcnt);
      @(posedge clk);
      #1;

      check("busy_done_overlap", 32'(overlap), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend; captured at start acceptance.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor; captured at start acceptance.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse, high while in DONE.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient of last completed division.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder of last completed division.
REQ-011 SHALL have port div_by_zero  output  1  registered; set when the last completed division had divisor 0.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start at an edge; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally on the next edge.
REQ-013 SHALL perform one restoring-division step per RUN edge: shift partial remainder left 1 and bring in the next dividend MSB; subtract the divisor via a (WIDTH+1)-bit difference; if the difference is non-negative, keep it and set the quotient bit to 1, else restore and set it to 0.
REQ-014 SHALL use an iteration counter running 0..WIDTH-1; the last step executes on the edge where the counter equals WIDTH-1.
REQ-015 SHALL have a latency where start sampled at edge E0 gives busy high for cycles after E0..E(WIDTH-1), done high for exactly the cycle after E(WIDTH), and IDLE after E(WIDTH+1); WIDTH=32 gives 33 edges from start to done.
REQ-016 SHALL update quotient, remainder and div_by_zero at the edge entering DONE and hold them until the next completion.
REQ-017 SHALL ignore start while in RUN or DONE, with no effect on the running operation or the captured operands.
REQ-018 SHALL never assert busy and done in the same cycle.
REQ-019 SHALL, for divisor 0 without the fast path, naturally produce quotient all-ones and remainder = dividend, with div_by_zero=1.
REQ-020 SHALL give results satisfying dividend = quotient*divisor + remainder and remainder < divisor for every non-zero divisor.

Reset
REQ-021 SHALL, when rst is high at an edge, enter IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, regardless of state.
REQ-022 SHALL treat reset mid-RUN as an abort: no done pulse, results stay 0, and a new start is accepted on the first edge after rst deasserts.
REQ-023 SHALL give rst priority over start on the same edge.

Configuration
REQ-024 SHALL, when macro SEQ_DIVIDER_ZERO_FAST_EN is defined, detect divisor==0 at start acceptance, go IDLE->DONE directly, and load quotient=all-ones, remainder=dividend, div_by_zero=1, with done high in the cycle after E0 and busy never asserted.
REQ-025 SHALL, without SEQ_DIVIDER_ZERO_FAST_EN, process divisor 0 through the full WIDTH-iteration RUN path per REQ-019, with the same results and standard latency.

Verification
REQ-026 SHALL cover: 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, done exactly 33 edges after start, busy high 32 cycles.
REQ-027 SHALL cover: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0; and 5 / 9 -> quotient 0, remainder 5.
REQ-028 SHALL cover: 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1; done after 33 edges without the macro, after 1 edge with it.
REQ-029 SHALL cover: start with 50 / 3 held, then start re-pulsed with 9 / 2 during RUN -> the second start is ignored; result quotient 16, remainder 2.
REQ-030 SHALL cover: rst asserted 10 cycles into RUN -> IDLE, all outputs 0, no done pulse; a following 81 / 9 gives quotient 9, remainder 0.
REQ-031 SHALL cover: back-to-back start held high continuously -> a new division starts on the first edge in IDLE after each DONE, with results 1000 / 10 = 100 r 0 each time.
